collision_scheduler: RTL and testbench
======================================

// Module: collision_scheduler
// PURPOSE
//  Time-multiplexes one collision_detection comparator across all live projectiles x alive aliens.
//  Per frame tick it walks (projectile, target) pairs in index order and drives the shared checker.
//  It reports each hit and hands a kill mask to the game FSM.
//  Sits between the projectile/alien-grid state registers and the single collision checker.
// PARAMETERS
//  NPROJ    4   number of projectile slots (index 0 = player bullet)
//  COLS     11  alien grid columns
//  ROWS     5   alien grid rows; NTGT = ROWS*COLS, target t = row*COLS+col
//  COORD_W  10  coordinate width (pixels)
//  X_PITCH  24  horizontal spacing between alien origins
//  Y_PITCH  16  vertical spacing between alien origins
// PORTS
//  clk         in   1               system clock; all state changes on posedge
//  rst         in   1               synchronous, active-high reset
//  start       in   1               one-cycle frame tick; begins a scan when idle
//  grid_x      in   COORD_W         upper-left x of alien (0,0)
//  grid_y      in   COORD_W         upper-left y of alien (0,0)
//  alive       in   NTGT            alive bit per target
//  proj_valid  in   NPROJ           projectile slot in flight
//  proj_x      in   NPROJ*COORD_W   packed x; slot p at [p*COORD_W +: COORD_W]
//  proj_y      in   NPROJ*COORD_W   packed y, same packing
//  chk_req     out  1               one-cycle strobe: chk_* operands valid
//  chk_obj_x   out  COORD_W         target x driven to checker
//  chk_obj_y   out  COORD_W         target y driven to checker
//  chk_proj_x  out  COORD_W         projectile x driven to checker
//  chk_proj_y  out  COORD_W         projectile y driven to checker
//  chk_hit     in   1               checker result, valid exactly 1 cycle after chk_req
//  busy        out  1               scan in progress
//  hit_valid   out  1               one-cycle pulse per detected hit
//  hit_proj    out  clog2(NPROJ)    projectile index of hit, valid with hit_valid
//  hit_tgt     out  clog2(NTGT)     target index of hit, valid with hit_valid
//  kill_mask   out  NPROJ           projectiles consumed this scan, valid from done
//  done        out  1               one-cycle pulse when scan completes
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; counters and snapshots cleared. rst mid-scan aborts the scan, with no done pulse.
//  FSM: IDLE -> LOAD -> (SCAN <-> WAIT) -> FIN -> IDLE.
//  IDLE: start=1 -> LOAD; busy=1 from the next cycle. start while busy is ignored, not queued.
//  LOAD (1 cycle): snapshot alive, proj_valid, proj_x/y, grid_x/y; p=0, t=0, kill_mask=0.
//   Inputs changing mid-scan have no effect.
//  SCAN, one pair per cycle:
//   - snapshot proj_valid[p]=0 -> p++, t=0;
//   - else if alive_snap[t]=0 -> t++;
//   - else assert chk_req with operands -> WAIT.
//   Skipped pairs cost 1 cycle each and issue no chk_req.
//  Operand math: obj_x = grid_x + col*X_PITCH; obj_y = grid_y + row*Y_PITCH.
//   Computed at COORD_W bits, modulo 2^COORD_W (wrap, no saturation).
//  WAIT (1 cycle): sample chk_hit.
//   On hit: hit_valid=1 with hit_proj=p, hit_tgt=t; alive_snap[t] cleared (no double kill); kill_mask[p] set.
//   Then advance as in SCAN.
//  Index wrap: t == NTGT-1 advancing -> t=0, p++. p == NPROJ-1 advancing -> FIN.
//  FIN: done=1 for 1 cycle, busy=0 next cycle, kill_mask held until next LOAD.
//  Zero valid projectiles: done exactly NPROJ+2 cycles after start (LOAD, NPROJ skips, FIN).
//  Lower p wins a target claimed by multiple projectiles in the same scan.
// CONFIGURATION
//  COLLISION_SCHED_MULTIHIT_EN undefined (default):
//   after a hit, projectile p retires immediately (p++, t=0); max one hit per projectile per scan.
//  COLLISION_SCHED_MULTIHIT_EN defined:
//   projectile continues over remaining targets (piercing shot); multiple hit_valid per p allowed.
//   kill_mask[p] is still set on the first hit.
// TESTING
//  1. rst held 2 cycles, then start -> all outputs 0 during reset; busy rises 1 cycle after start.
//  2. proj_valid=0, start -> no chk_req; done exactly 6 cycles after start (NPROJ=4); kill_mask=0.
//  3. grid=(100,50), only alive[12] set, proj 0 valid, checker hits:
//     -> chk_obj=(124,66), hit_valid with hit_proj=0, hit_tgt=12, kill_mask=0001.
//  4. Projs 0 and 2 both hit target 3 -> one hit (proj 0); proj 2 issues no chk_req for t=3; kill_mask=0001.
//  5. grid_x=1020, col 1 -> chk_obj_x=20 (wrap mod 1024).
//     start pulsed mid-scan -> ignored; rst mid-scan -> IDLE, no done.
//  6. MULTIHIT_EN, proj 0 vs alive 0..2 all hit -> 3 hit_valid pulses (t=0,1,2); without macro: 1 pulse.

Source files
------------

// File: rtl/collision_scheduler.sv
// collision_scheduler: walks every (projectile, alien) pair once per frame tick and
// time-shares a single external collision checker across them.
// Optional build macro COLLISION_SCHED_MULTIHIT_EN: when defined a projectile keeps
// scanning after a hit (piercing shot); otherwise it retires on its first hit.
module collision_scheduler #(
  parameter int NPROJ   = 4,
  parameter int COLS    = 11,
  parameter int ROWS    = 5,
  parameter int COORD_W = 10,
  parameter int X_PITCH = 24,
  parameter int Y_PITCH = 16,
  localparam int NTGT   = ROWS * COLS,
  localparam int PW     = (NPROJ > 1) ? $clog2(NPROJ) : 1,
  localparam int TW     = (NTGT > 1) ? $clog2(NTGT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COORD_W-1:0]       grid_x,
  input  logic [COORD_W-1:0]       grid_y,
  input  logic [NTGT-1:0]          alive,
  input  logic [NPROJ-1:0]         proj_valid,
  input  logic [NPROJ*COORD_W-1:0] proj_x,
  input  logic [NPROJ*COORD_W-1:0] proj_y,
  output logic                     chk_req,
  output logic [COORD_W-1:0]       chk_obj_x,
  output logic [COORD_W-1:0]       chk_obj_y,
  output logic [COORD_W-1:0]       chk_proj_x,
  output logic [COORD_W-1:0]       chk_proj_y,
  input  logic                     chk_hit,
  output logic                     busy,
  output logic                     hit_valid,
  output logic [PW-1:0]            hit_proj,
  output logic [TW-1:0]            hit_tgt,
  output logic [NPROJ-1:0]         kill_mask,
  output logic                     done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StScan = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StFin  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [PW-1:0]            p_q, p_d;
  logic [TW-1:0]            t_q, t_d;
  // Column/row tracked alongside t so operand math needs no divider.
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic [NTGT-1:0]          alive_q, alive_d;
  logic [NPROJ-1:0]         kill_q, kill_d;
  logic [NPROJ-1:0]         pv_q;
  logic [NPROJ*COORD_W-1:0] px_q, py_q;
  logic [COORD_W-1:0]       gx_q, gy_q;
  logic                     adv_t, retire;
  logic                     last_t, last_p;

  assign last_t = (t_q == TW'(NTGT - 1));
  assign last_p = (p_q == PW'(NPROJ - 1));

  // Next-state: pair walk, hit bookkeeping and index wrap.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    t_d     = t_q;
    col_d   = col_q;
    row_d   = row_q;
    alive_d = alive_q;
    kill_d  = kill_q;
    adv_t   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: begin
        state_d = StScan;
        p_d     = '0;
        t_d     = '0;
        col_d   = '0;
        row_d   = '0;
        kill_d  = '0;
        alive_d = alive;
      end
      StScan: begin
        if (!pv_q[p_q])         retire  = 1'b1;
        else if (!alive_q[t_q]) adv_t   = 1'b1;
        else                    state_d = StWait;
      end
      StWait: begin
        state_d = StScan;
        if (chk_hit) begin
          // Clearing the snapshot bit keeps later projectiles off a claimed target.
          alive_d[t_q] = 1'b0;
          kill_d[p_q]  = 1'b1;
`ifdef COLLISION_SCHED_MULTIHIT_EN
          adv_t = 1'b1;
`else
          retire = 1'b1;
`endif
        end else begin
          adv_t = 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (adv_t && !last_t) begin
      t_d = t_q + 1'b1;
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (adv_t || retire) begin
      t_d   = '0;
      col_d = '0;
      row_d = '0;
      if (last_p) state_d = StFin;
      else        p_d     = p_q + 1'b1;
    end
  end

  // State, counters and input snapshots.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      p_q     <= '0;
      t_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      alive_q <= '0;
      kill_q  <= '0;
      pv_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      t_q     <= t_d;
      col_q   <= col_d;
      row_q   <= row_d;
      alive_q <= alive_d;
      kill_q  <= kill_d;
      if (state_q == StLoad) begin
        pv_q <= proj_valid;
        px_q <= proj_x;
        py_q <= proj_y;
        gx_q <= grid_x;
        gy_q <= grid_y;
      end
    end
  end

  // Outputs decoded from state and snapshots; operand sums wrap at COORD_W bits.
  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StFin);
    chk_req    = (state_q == StScan) && pv_q[p_q] && alive_q[t_q];
    hit_valid  = (state_q == StWait) && chk_hit;
    hit_proj   = p_q;
    hit_tgt    = t_q;
    kill_mask  = kill_q;
    chk_obj_x  = gx_q + COORD_W'(int'(col_q) * X_PITCH);
    chk_obj_y  = gy_q + COORD_W'(int'(row_q) * Y_PITCH);
    chk_proj_x = px_q[p_q*COORD_W +: COORD_W];
    chk_proj_y = py_q[p_q*COORD_W +: COORD_W];
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: reference model walks the pair list
// with plain loops and modulo arithmetic; a behavioural checker answers chk_req.
module tb_collision_scheduler;
  localparam int NPROJ = 4;
  localparam int COLS  = 11;
  localparam int ROWS  = 5;
  localparam int NTGT  = ROWS * COLS;
`ifdef COLLISION_SCHED_MULTIHIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, chk_hit;
  logic [9:0]  grid_x, grid_y;
  logic [NTGT-1:0] alive;
  logic [3:0]  proj_valid;
  logic [39:0] proj_x, proj_y;
  logic        chk_req, busy, hit_valid, done;
  logic [9:0]  chk_obj_x, chk_obj_y, chk_proj_x, chk_proj_y;
  logic [1:0]  hit_proj;
  logic [5:0]  hit_tgt;
  logic [3:0]  kill_mask;

  collision_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .grid_x(grid_x), .grid_y(grid_y),
    .alive(alive), .proj_valid(proj_valid), .proj_x(proj_x), .proj_y(proj_y),
    .chk_req(chk_req), .chk_obj_x(chk_obj_x), .chk_obj_y(chk_obj_y),
    .chk_proj_x(chk_proj_x), .chk_proj_y(chk_proj_y), .chk_hit(chk_hit),
    .busy(busy), .hit_valid(hit_valid), .hit_proj(hit_proj), .hit_tgt(hit_tgt),
    .kill_mask(kill_mask), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int force_hit = 0;

  // Scenario inputs (what the scan should snapshot).
  logic [9:0]      g_gx, g_gy;
  logic [NTGT-1:0] g_alive;
  logic [3:0]      g_pv;
  logic [9:0]      g_px[NPROJ];
  logic [9:0]      g_py[NPROJ];

  logic [39:0] obs_chk[$], exp_chk[$];
  int          obs_hit[$], exp_hit[$];
  int          done_cnt, done_cyc, start_cyc, exp_cost;
  logic [3:0]  obs_kill, exp_kill;

  function automatic bit rule(input int ox, input int oy, input int px, input int py);
    return (px >= ox) && (px < ox + 16) && (py >= oy) && (py < oy + 8);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural checker: answers one cycle after each request.
  always @(posedge clk)
    chk_hit <= chk_req && ((force_hit != 0) ||
               rule(int'(chk_obj_x), int'(chk_obj_y), int'(chk_proj_x), int'(chk_proj_y)));

  always @(negedge clk) begin
    if (!rst) begin
      if (chk_req) obs_chk.push_back({chk_obj_x, chk_obj_y, chk_proj_x, chk_proj_y});
      if (hit_valid) obs_hit.push_back(int'(hit_proj) * 64 + int'(hit_tgt));
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
        obs_kill = kill_mask;
      end
    end
  end

  // Reference: visit pairs in index order, one cycle per visit plus one per check.
  task automatic model();
    logic [NTGT-1:0] al;
    logic [9:0] ox, oy;
    al = g_alive;
    exp_chk.delete();
    exp_hit.delete();
    exp_kill = '0;
    exp_cost = 0;
    for (int p = 0; p < NPROJ; p++) begin
      if (!g_pv[p]) begin
        exp_cost++;
        continue;
      end
      for (int t = 0; t < NTGT; t++) begin
        exp_cost++;
        if (!al[t]) continue;
        ox = 10'((int'(g_gx) + (t % COLS) * 24) % 1024);
        oy = 10'((int'(g_gy) + (t / COLS) * 16) % 1024);
        exp_cost++;
        exp_chk.push_back({ox, oy, g_px[p], g_py[p]});
        if (force_hit != 0 || rule(int'(ox), int'(oy), int'(g_px[p]), int'(g_py[p]))) begin
          exp_hit.push_back(p * 64 + t);
          al[t] = 1'b0;
          exp_kill[p] = 1'b1;
          if (!MULTI) break;
        end
      end
    end
  endtask

  task automatic drive_inputs();
    grid_x = g_gx;
    grid_y = g_gy;
    alive = g_alive;
    proj_valid = g_pv;
    for (int p = 0; p < NPROJ; p++) begin
      proj_x[p*10 +: 10] = g_px[p];
      proj_y[p*10 +: 10] = g_py[p];
    end
  endtask

  // mode 0: plain scan; 1: perturb inputs and re-pulse start mid-scan; 2: reset mid-scan.
  task automatic run_scan(input int mode);
    obs_chk.delete();
    obs_hit.delete();
    done_cnt = 0;
    obs_kill = 'x;
    model();
    drive_inputs();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      alive = '1;
      proj_valid = 4'hF;
      grid_x = grid_x + 10'd7;
      proj_x = ~proj_x;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (mode == 2) begin
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (120) @(posedge clk);
    end else begin
      for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
    end
    #1;
  endtask

  task automatic clear_scenario();
    g_gx = '0; g_gy = '0; g_alive = '0; g_pv = '0; force_hit = 0;
    for (int p = 0; p < NPROJ; p++) begin
      g_px[p] = '0;
      g_py[p] = '0;
    end
  endtask

  task automatic test_reset();
    logic [60:0] outs;
    rst = 1'b1;
    start = 1'b1;
    alive = '1;
    proj_valid = 4'hF;
    proj_x = '1;
    proj_y = '1;
    grid_x = 10'h3FF;
    grid_y = 10'h3FF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      outs = {chk_req, chk_obj_x, chk_obj_y, chk_proj_x, chk_proj_y, busy, hit_valid,
              hit_proj, hit_tgt, kill_mask, done};
      tests++;
      if (outs !== '0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    clear_scenario();
    drive_inputs();
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_before_start: got %b want 0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_no_proj();
    clear_scenario();
    g_alive = '1;
    run_scan(0);
    tests++;
    if (obs_chk.size() != 0) begin
      fails++;
      $display("FAIL no_proj_chk_req: got %0d requests want 0", obs_chk.size());
    end
    tests++;
    if (done_cnt != 1 || done_cyc - start_cyc != 6) begin
      fails++;
      $display("FAIL no_proj_done: got count %0d at +%0d want 1 at +6",
               done_cnt, done_cyc - start_cyc);
    end
    tests++;
    if (obs_kill !== 4'b0000) begin
      fails++;
      $display("FAIL no_proj_kill: got %b want 0000", obs_kill);
    end
  endtask

  task automatic test_single_hit();
    clear_scenario();
    g_gx = 10'd100;
    g_gy = 10'd50;
    g_alive[12] = 1'b1;
    g_pv = 4'b0001;
    g_px[0] = 10'd130;
    g_py[0] = 10'd70;
    force_hit = 1;
    run_scan(0);
    tests++;
    if (obs_chk.size() != 1 || obs_chk[0][39:20] !== {10'd124, 10'd66}) begin
      fails++;
      $display("FAIL single_operands: got n=%0d obj=%h want n=1 obj=%h",
               obs_chk.size(), (obs_chk.size() > 0) ? obs_chk[0][39:20] : 20'h0,
               {10'd124, 10'd66});
    end
    tests++;
    if (obs_hit.size() != 1 || obs_hit[0] != 12) begin
      fails++;
      $display("FAIL single_hit: got n=%0d first=%0d want proj0/tgt12", obs_hit.size(),
               (obs_hit.size() > 0) ? obs_hit[0] : -1);
    end
    tests++;
    if (obs_kill !== 4'b0001) begin
      fails++;
      $display("FAIL single_kill: got %b want 0001", obs_kill);
    end
    tests++;
    if (done_cnt != 1 || done_cyc - start_cyc != exp_cost + 2) begin
      fails++;
      $display("FAIL single_latency: got count %0d at +%0d want 1 at +%0d",
               done_cnt, done_cyc - start_cyc, exp_cost + 2);
    end
  endtask

  task automatic test_shared_target();
    clear_scenario();
    g_alive[3] = 1'b1;
    g_pv = 4'b0101;
    g_px[0] = 10'd11;
    g_px[2] = 10'd22;
    force_hit = 1;
    run_scan(0);
    tests++;
    if (obs_chk.size() != 1 || obs_chk[0][19:10] !== 10'd11) begin
      fails++;
      $display("FAIL shared_requests: got n=%0d want 1 request from proj 0", obs_chk.size());
    end
    tests++;
    if (obs_hit.size() != 1 || obs_hit[0] != 3) begin
      fails++;
      $display("FAIL shared_hit: got n=%0d first=%0d want proj0/tgt3", obs_hit.size(),
               (obs_hit.size() > 0) ? obs_hit[0] : -1);
    end
    tests++;
    if (obs_kill !== 4'b0001) begin
      fails++;
      $display("FAIL shared_kill: got %b want 0001", obs_kill);
    end
  endtask

  task automatic test_wrap_and_ignore();
    clear_scenario();
    g_gx = 10'd1020;
    g_gy = 10'd5;
    g_alive[1] = 1'b1;
    g_pv = 4'b0001;
    g_px[0] = 10'd300;
    run_scan(1);
    tests++;
    if (obs_chk.size() != 1 || obs_chk[0][39:30] !== 10'd20) begin
      fails++;
      $display("FAIL wrap_obj_x: got n=%0d x=%0d want n=1 x=20", obs_chk.size(),
               (obs_chk.size() > 0) ? obs_chk[0][39:30] : 10'd0);
    end
    tests++;
    if (done_cnt != 1 || done_cyc - start_cyc != exp_cost + 2 || obs_hit.size() != 0) begin
      fails++;
      $display("FAIL ignore_midscan: got done %0d at +%0d hits %0d want 1 at +%0d hits 0",
               done_cnt, done_cyc - start_cyc, obs_hit.size(), exp_cost + 2);
    end
    clear_scenario();
    g_alive = '1;
    g_pv = 4'hF;
    run_scan(2);
    tests++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: got done %0d busy %b want 0 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_multihit();
    clear_scenario();
    g_alive[2:0] = 3'b111;
    g_pv = 4'b0001;
    force_hit = 1;
    run_scan(0);
    tests++;
    if (obs_hit.size() != (MULTI ? 3 : 1)) begin
      fails++;
      $display("FAIL multihit_count: got %0d want %0d", obs_hit.size(), MULTI ? 3 : 1);
    end
    for (int i = 0; i < obs_hit.size() && i < 3; i++) begin
      tests++;
      if (obs_hit[i] != i) begin
        fails++;
        $display("FAIL multihit_tgt[%0d]: got %0d want %0d", i, obs_hit[i], i);
      end
    end
    tests++;
    if (obs_kill !== 4'b0001) begin
      fails++;
      $display("FAIL multihit_kill: got %b want 0001", obs_kill);
    end
  endtask

  task automatic test_random();
    int tg;
    for (int it = 0; it < 40; it++) begin
      clear_scenario();
      g_gx = 10'($urandom_range(0, 1023));
      g_gy = 10'($urandom_range(0, 1023));
      g_alive = NTGT'({$urandom, $urandom});
      if (it % 3 == 0) g_alive = g_alive & NTGT'({$urandom, $urandom});
      g_pv = 4'($urandom);
      for (int p = 0; p < NPROJ; p++) begin
        tg = $urandom_range(0, NTGT - 1);
        g_px[p] = 10'((int'(g_gx) + (tg % COLS) * 24 + $urandom_range(0, 20)) % 1024);
        g_py[p] = 10'((int'(g_gy) + (tg / COLS) * 16 + $urandom_range(0, 10)) % 1024);
      end
      run_scan(0);
      tests++;
      if (done_cnt != 1 || done_cyc - start_cyc != exp_cost + 2) begin
        fails++;
        $display("FAIL rand%0d_done: got count %0d at +%0d want 1 at +%0d", it, done_cnt,
                 done_cyc - start_cyc, exp_cost + 2);
      end
      tests++;
      if (obs_chk.size() != exp_chk.size()) begin
        fails++;
        $display("FAIL rand%0d_nreq: got %0d want %0d", it, obs_chk.size(), exp_chk.size());
      end else begin
        for (int i = 0; i < exp_chk.size(); i++) begin
          if (obs_chk[i] !== exp_chk[i]) begin
            fails++;
            $display("FAIL rand%0d_req[%0d]: got %h want %h", it, i, obs_chk[i], exp_chk[i]);
            break;
          end
        end
      end
      tests++;
      if (obs_hit != exp_hit) begin
        fails++;
        $display("FAIL rand%0d_hits: got n=%0d want n=%0d", it, obs_hit.size(), exp_hit.size());
      end
      tests++;
      if (obs_kill !== exp_kill) begin
        fails++;
        $display("FAIL rand%0d_kill: got %b want %b", it, obs_kill, exp_kill);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    clear_scenario();
    drive_inputs();
    test_reset();
    test_no_proj();
    test_single_hit();
    test_shared_target();
    test_wrap_and_ignore();
    test_multihit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
